// File: rtl/z80_refresh_unit_pkg.sv
// ============================================================================
// Module  : z80_refresh_unit_pkg
// Purpose : Shared flag bit positions, read-FSM states and ld_sel encodings
//           for the Z80 I/R refresh unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package z80_refresh_unit_pkg;

  localparam int unsigned FLAG_S  = 7;
  localparam int unsigned FLAG_Z  = 6;
  localparam int unsigned FLAG_F5 = 5;
  localparam int unsigned FLAG_H  = 4;
  localparam int unsigned FLAG_F3 = 3;
  localparam int unsigned FLAG_PV = 2;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_C  = 0;

  localparam logic LD_SEL_R = 1'b0;
  localparam logic LD_SEL_I = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/z80_refresh_unit_popcount_inc.sv
// ============================================================================
// Module  : z80_popcount_inc
// Purpose : Adds the number of set M1 strobes to the R counting field,
//           wrapping modulo 2^CNT_WIDTH.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_popcount_inc #(
  parameter int CNT_WIDTH = 7,
  parameter int LANES     = 1
) (
  input  logic [LANES-1:0]     i_strobe,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  // Accumulating in the field width gives the wrap for free.
  always_comb begin
    o_cnt = i_cnt;
    for (int k = 0; k < LANES; k++) begin
      o_cnt = o_cnt + CNT_WIDTH'(i_strobe[k]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/z80_refresh_unit.sv
// ============================================================================
// Module  : z80_refresh_unit
// Purpose : Owns Z80 I/R, counts M1 fetches into R, drives refresh address and
//           executes the read side of LD A,R / LD A,I.
// Config  : Z80_NMOS_IFF2_BUG_EN - int_ack in the read cycle forces PV to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_refresh_unit
  import z80_refresh_unit_pkg::*;
#(
  parameter int R_CNT_WIDTH = 7,
  parameter int M1_LANES    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [M1_LANES-1:0] m1_done,
  input  logic                r_wr_en,
  input  logic                i_wr_en,
  input  logic [7:0]          wr_data,
  input  logic                ld_req,
  input  logic                ld_sel,
  input  logic [7:0]          f_in,
  input  logic                iff2,
  input  logic                int_ack,
  output logic                res_valid,
  output logic [7:0]          res_a,
  output logic [7:0]          res_f,
  output logic [7:0]          r_out,
  output logic [7:0]          i_out,
  output logic                refresh_valid,
  output logic [15:0]         refresh_addr
);

  logic [7:0]             r_r;
  logic [7:0]             r_i;
  logic [7:0]             r_res_a;
  logic [7:0]             r_res_f;
  logic                   r_refresh_valid;
  logic [15:0]            r_refresh_addr;
  rd_state_e              r_state;
  rd_state_e              w_state_next;
  logic                   w_res_valid;
  logic [R_CNT_WIDTH-1:0] w_cnt_next;
  logic [7:0]             w_r_inc;
  logic [7:0]             w_r_next;
  logic [7:0]             w_i_next;
  logic [7:0]             w_v;
  logic                   w_pv;
  logic [7:0]             w_flags;
  logic                   w_unused_f;

  z80_popcount_inc #(
    .CNT_WIDTH (R_CNT_WIDTH),
    .LANES     (M1_LANES)
  ) u_popcount_inc (
    .i_strobe (m1_done),
    .i_cnt    (r_r[R_CNT_WIDTH-1:0]),
    .o_cnt    (w_cnt_next)
  );

  generate
    if (R_CNT_WIDTH < 8) begin : g_upper_hold
      assign w_r_inc = {r_r[7:R_CNT_WIDTH], w_cnt_next};
    end else begin : g_full_count
      assign w_r_inc = w_cnt_next;
    end
  endgenerate

  assign w_r_next = r_wr_en ? wr_data : w_r_inc;
  assign w_i_next = i_wr_en ? wr_data : r_i;
  // Read samples post-update values so LD A,R sees its own opcode fetches.
  assign w_v      = (ld_sel == LD_SEL_I) ? w_i_next : w_r_next;

`ifdef Z80_NMOS_IFF2_BUG_EN
  assign w_pv = iff2 & ~int_ack;
`else
  logic w_unused_int_ack;
  assign w_unused_int_ack = int_ack;
  assign w_pv = iff2;
`endif

  assign w_unused_f = ^{f_in[FLAG_S], f_in[FLAG_Z], f_in[FLAG_H], f_in[FLAG_PV], f_in[FLAG_N]};

  always_comb begin
    w_flags          = 8'h00;
    w_flags[FLAG_S]  = w_v[7];
    w_flags[FLAG_Z]  = (w_v == 8'h00);
    w_flags[FLAG_F5] = f_in[FLAG_F5];
    w_flags[FLAG_F3] = f_in[FLAG_F3];
    w_flags[FLAG_PV] = w_pv;
    w_flags[FLAG_C]  = f_in[FLAG_C];
  end

  always_comb begin
    w_state_next = r_state;
    w_res_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ld_req) w_state_next = ST_RESULT;
      end
      ST_RESULT: begin
        w_res_valid  = 1'b1;
        w_state_next = ld_req ? ST_RESULT : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_r             <= 8'h00;
      r_i             <= 8'h00;
      r_res_a         <= 8'h00;
      r_res_f         <= 8'h00;
      r_refresh_valid <= 1'b0;
      r_refresh_addr  <= 16'h0000;
    end else begin
      r_state         <= w_state_next;
      r_r             <= w_r_next;
      r_i             <= w_i_next;
      r_refresh_valid <= |m1_done;
      if (|m1_done) r_refresh_addr <= {r_i, r_r};
      if (ld_req) begin
        r_res_a <= w_v;
        r_res_f <= w_flags;
      end
    end
  end

  assign res_valid     = w_res_valid;
  assign res_a         = r_res_a;
  assign res_f         = r_res_f;
  assign r_out         = r_r;
  assign i_out         = r_i;
  assign refresh_valid = r_refresh_valid;
  assign refresh_addr  = r_refresh_addr;

endmodule

`default_nettype wire

// File: tb/tb_z80_refresh_unit.sv
// ============================================================================
// Module  : tb_z80_refresh_unit
// Purpose : Scoreboard bench for z80_refresh_unit (7-bit/2-lane and 8-bit/1-lane).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_z80_refresh_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m1;
  logic        m1_8;
  logic        r_wr_en, i_wr_en, ld_req, ld_sel, iff2, int_ack;
  logic [7:0]  wr_data, f_in;

  logic        res_valid, refresh_valid;
  logic [7:0]  res_a, res_f, r_out, i_out;
  logic [15:0] refresh_addr;

  logic        res_valid8, refresh_valid8;
  logic [7:0]  res_a8, res_f8, r_out8, i_out8;
  logic [15:0] refresh_addr8;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [15:0] exp_res_q[$];
  logic [15:0] exp_ref_q[$];

  always #5 clk = ~clk;
  assign m1_8 = m1[0];

  z80_refresh_unit #(.R_CNT_WIDTH(7), .M1_LANES(2)) u_dut (
    .clk(clk), .reset(reset), .m1_done(m1), .r_wr_en(r_wr_en), .i_wr_en(i_wr_en),
    .wr_data(wr_data), .ld_req(ld_req), .ld_sel(ld_sel), .f_in(f_in), .iff2(iff2),
    .int_ack(int_ack), .res_valid(res_valid), .res_a(res_a), .res_f(res_f),
    .r_out(r_out), .i_out(i_out), .refresh_valid(refresh_valid), .refresh_addr(refresh_addr)
  );

  z80_refresh_unit #(.R_CNT_WIDTH(8), .M1_LANES(1)) u_dut8 (
    .clk(clk), .reset(reset), .m1_done(m1_8), .r_wr_en(r_wr_en), .i_wr_en(i_wr_en),
    .wr_data(wr_data), .ld_req(ld_req), .ld_sel(ld_sel), .f_in(f_in), .iff2(iff2),
    .int_ack(int_ack), .res_valid(res_valid8), .res_a(res_a8), .res_f(res_f8),
    .r_out(r_out8), .i_out(i_out8), .refresh_valid(refresh_valid8), .refresh_addr(refresh_addr8)
  );

  // Monitor: pops expectations whenever the DUT presents a result or refresh.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_en) begin
      if (res_valid) begin
        n_checks++;
        if (exp_res_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: got a=%h f=%h, required no result", res_a, res_f);
        end else begin
          e = exp_res_q.pop_front();
          if ({res_a, res_f} !== e) begin
            n_fail++;
            $display("FAIL result: got a=%h f=%h, required a=%h f=%h", res_a, res_f, e[15:8], e[7:0]);
          end
        end
      end
      if (refresh_valid) begin
        n_checks++;
        if (exp_ref_q.size() == 0) begin
          n_fail++;
          $display("FAIL refresh_unexpected: got addr=%h, required no refresh", refresh_addr);
        end else begin
          e = exp_ref_q.pop_front();
          if (refresh_addr !== e) begin
            n_fail++;
            $display("FAIL refresh_addr: got %h, required %h", refresh_addr, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m1 = 2'b00; r_wr_en = 1'b0; i_wr_en = 1'b0; wr_data = 8'h00;
    ld_req = 1'b0; ld_sel = 1'b0; f_in = 8'h00; iff2 = 1'b0; int_ack = 1'b0;
  endtask

  localparam logic [7:0] C_PV_ACK =
`ifdef Z80_NMOS_IFF2_BUG_EN
    8'h40;
`else
    8'h44;
`endif

  initial begin
    clr();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_r", {8'h00, r_out}, 16'h0000);
    check("reset_i", {8'h00, i_out}, 16'h0000);
    check("reset_valids", {14'h0, res_valid, refresh_valid}, 16'h0000);
    check("reset_res", {res_a, res_f}, 16'h0000);
    check("reset_refresh_addr", refresh_addr, 16'h0000);
    mon_en = 1'b1;

    // Three single fetches
    m1 = 2'b01; exp_ref_q.push_back(16'h0000); tick();
    exp_ref_q.push_back(16'h0001); tick();
    exp_ref_q.push_back(16'h0002); tick();
    clr();
    @(negedge clk);
    check("r_after_3", {8'h00, r_out}, 16'h0003);
    check("r8_after_3", {8'h00, r_out8}, 16'h0003);

    // Bit 7 hold with 7-bit field, full wrap with 8-bit field
    r_wr_en = 1'b1; wr_data = 8'hFF; tick(); clr();
    m1 = 2'b01; exp_ref_q.push_back(16'h00FF); tick(); clr();
    @(negedge clk);
    check("r_wrap7", {8'h00, r_out}, 16'h0080);
    check("r_wrap8", {8'h00, r_out8}, 16'h0000);

    // Write beats same-cycle increments; two lanes add two
    r_wr_en = 1'b1; wr_data = 8'h10; m1 = 2'b11; exp_ref_q.push_back(16'h0080); tick(); clr();
    m1 = 2'b11; exp_ref_q.push_back(16'h0010); tick(); clr();
    @(negedge clk);
    check("r_two_lanes", {8'h00, r_out}, 16'h0012);
    check("r8_one_lane", {8'h00, r_out8}, 16'h0011);

    // LD A,R seeing its own fetch
    r_wr_en = 1'b1; wr_data = 8'h7E; tick(); clr();
    ld_req = 1'b1; ld_sel = 1'b0; m1 = 2'b01; f_in = 8'hFF; iff2 = 1'b1;
    exp_ref_q.push_back(16'h007E); exp_res_q.push_back(16'h7F2D); tick(); clr();
    @(negedge clk);
    check("r_after_ldar", {8'h00, r_out}, 16'h007F);

    // LD A,I with same-cycle I write (sign set)
    i_wr_en = 1'b1; wr_data = 8'hA5; ld_req = 1'b1; ld_sel = 1'b1;
    exp_res_q.push_back(16'hA580); tick(); clr();
    @(negedge clk);
    check("i_write", {8'h00, i_out}, 16'h00A5);

    // Refresh carries I; R 7F wraps to 00 with bit 7 clear
    m1 = 2'b01; exp_ref_q.push_back(16'hA57F); tick(); clr();
    ld_req = 1'b1; ld_sel = 1'b0; exp_res_q.push_back(16'h0040); tick(); clr();
    @(negedge clk);
    check("r_wrap_7f", {8'h00, r_out}, 16'h0000);

    // LD A,I with I=0
    i_wr_en = 1'b1; wr_data = 8'h00; tick(); clr();
    ld_req = 1'b1; ld_sel = 1'b1; exp_res_q.push_back(16'h0040); tick(); clr();

    // int_ack during read, then back-to-back read
    ld_req = 1'b1; iff2 = 1'b1; int_ack = 1'b1; exp_res_q.push_back({8'h00, C_PV_ACK}); tick(); clr();
    ld_req = 1'b1; iff2 = 1'b1; exp_res_q.push_back(16'h0044);
    @(negedge clk);
    check("b2b_valid_1", {15'h0, res_valid}, 16'h0001);
    tick(); clr();
    @(negedge clk);
    check("b2b_valid_2", {15'h0, res_valid}, 16'h0001);
    tick();
    @(negedge clk);
    check("b2b_valid_end", {15'h0, res_valid}, 16'h0000);

    // Reset while in RESULT drops the state
    ld_req = 1'b1; ld_sel = 1'b1; f_in = 8'hFF; exp_res_q.push_back(16'h0069); tick(); clr();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_result", {15'h0, res_valid}, 16'h0000);
    check("reset_in_result_res", {res_a, res_f}, 16'h0000);
    tick(); tick();
    @(negedge clk);
    check("res_queue_empty", 16'(exp_res_q.size()), 16'h0000);
    check("ref_queue_empty", 16'(exp_ref_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
